// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: data width, default bit timing and receiver states.
package uart_rx_pkg;

   localparam int unsigned DATA_BITS        = 8;
   // 50 MHz system clock at 9600 baud.
   localparam int unsigned CLKS_PER_BIT_DEF = 5208;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StStart = 3'd1,
      StData  = 3'd2,
      StStop  = 3'd3,
      StBreak = 3'd4
   } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops; both reset to the line's idle level.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, framing-error detection, line-break hold-off.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic                 clk,
   input  logic                 rx_rst,
   input  logic                 rx_serial_in,
   output logic [DATA_BITS-1:0] rx_data_out,
   output logic                 rx_valid,
   output logic                 rx_busy,
   output logic                 rx_frame_err
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

   logic                 rx_s;
   rx_state_e            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;

   uart_sync2 #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rx_rst),
      .d   (rx_serial_in),
      .q   (rx_s)
   );

   // State, timing and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rx_rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   // Next-state logic; the counter restarts from zero on every transition and every sample.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (!rx_s) state_d = StStart;
         end
         StStart: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               // A high line at mid start bit was only a glitch.
               state_d = rx_s ? StIdle : StData;
            end
         end
         StData: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d          = '0;
               shreg_d[idx_q] = rx_s;
               if (idx_q == IDX_LAST) state_d = StStop;
               else                   idx_d   = idx_q + 3'd1;
            end
         end
         StStop: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = StBreak;
               end
            end
         end
         StBreak: begin
            // Wait out a held-low line so it cannot be taken as a new start bit.
            cnt_d = '0;
            if (rx_s) state_d = StIdle;
         end
         default: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   assign rx_data_out  = data_q;
   assign rx_valid     = valid_q;
   assign rx_frame_err = ferr_q;
   assign rx_busy      = (state_q == StStart) || (state_q == StData) || (state_q == StStop);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serializer drives frames, a monitor checks events.
module tb_uart_rx;

   localparam int C = 4;

   typedef struct packed {
      logic       is_err;
      logic [7:0] data;
   } ev_t;

   logic       clk = 1'b0;
   logic       rx_rst = 1'b1;
   logic       rx_in = 1'b1;
   logic [7:0] rx_data_out;
   logic       rx_valid;
   logic       rx_busy;
   logic       rx_frame_err;

   int         total = 0;
   int         bad = 0;
   ev_t        exp_q[$];
   logic [7:0] last_good = 8'h00;

   bit         meas_en = 1'b0;
   bit         seen_high = 1'b0;
   int         low_run = 0;
   int         max_low = 0;

   uart_rx #(
      .CLKS_PER_BIT (C)
   ) dut (
      .clk          (clk),
      .rx_rst       (rx_rst),
      .rx_serial_in (rx_in),
      .rx_data_out  (rx_data_out),
      .rx_valid     (rx_valid),
      .rx_busy      (rx_busy),
      .rx_frame_err (rx_frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input int n);
      rx_in = v;
      repeat (n) @(negedge clk);
   endtask

   // Serialize one 8N1 frame; the expected event is queued before the first bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      ev_t ev;
      ev.is_err = ~stop_v;
      ev.data   = stop_v ? b : last_good;
      if (stop_v) last_good = b;
      exp_q.push_back(ev);
      drive(1'b0, C);
      for (int i = 0; i < 8; i++) drive(b[i], C);
      drive(stop_v, C);
   endtask

   // Monitor: pops the scoreboard on every output event; also tracks busy gaps.
   initial begin
      ev_t ev;
      forever begin
         @(negedge clk);
         if (rx_valid && rx_frame_err) begin
            total++;
            bad++;
            $display("FAIL valid_and_err: both high, data %0h", rx_data_out);
         end else if (rx_valid || rx_frame_err) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_event: valid=%0b err=%0b data=%0h expected none",
                        rx_valid, rx_frame_err, rx_data_out);
            end else begin
               ev = exp_q.pop_front();
               check("event_kind_is_err", 32'(rx_frame_err), 32'(ev.is_err));
               check("event_data", 32'(rx_data_out), 32'(ev.data));
            end
         end
         if (meas_en) begin
            if (rx_busy) begin
               if (seen_high && low_run > max_low) max_low = low_run;
               seen_high = 1'b1;
               low_run   = 0;
            end else begin
               low_run++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen_busy;
      bit returned;
      logic [7:0] b;

      repeat (3) @(negedge clk);
      rx_rst = 1'b0;
      check("reset_data", 32'(rx_data_out), 32'h00);
      check("reset_valid", 32'(rx_valid), 32'h0);
      check("reset_busy", 32'(rx_busy), 32'h0);
      check("reset_err", 32'(rx_frame_err), 32'h0);
      drive(1'b1, 2 * C);

      // Two ordinary frames.
      send_frame(8'h55, 1'b1);
      drive(1'b1, C);
      send_frame(8'h37, 1'b1);
      drive(1'b1, 2 * C);

      // Back-to-back: the stop sample lands mid stop bit, so idle lasts the other half bit.
      meas_en = 1'b1;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      meas_en = 1'b0;
      check("b2b_busy_gap_le_half_bit", 32'(max_low <= C - C / 2), 32'h1);
      check("b2b_busy_gap_seen", 32'(seen_high), 32'h1);
      drive(1'b1, 2 * C);

      // One-clock glitch: a false start that must abort silently.
      drive(1'b0, 1);
      rx_in     = 1'b1;
      seen_busy = 1'b0;
      returned  = 1'b0;
      for (int k = 0; k < C / 2 + 3 && !returned; k++) begin
         @(negedge clk);
         if (rx_busy) seen_busy = 1'b1;
         else if (seen_busy) returned = 1'b1;
      end
      check("glitch_busy_returns_low", 32'(returned), 32'h1);
      drive(1'b1, 2 * C);

      // Framing error followed by a long break, then a good frame.
      send_frame(8'hA5, 1'b0);
      drive(1'b0, 10 * C);
      check("break_busy_low", 32'(rx_busy), 32'h0);
      check("break_data_held", 32'(rx_data_out), 32'(last_good));
      drive(1'b0, 10 * C);
      drive(1'b1, 2 * C);
      send_frame(8'h3C, 1'b1);
      drive(1'b1, 2 * C);

      // Reset during data bit 4 of 0x96; the partial byte must vanish.
      b = 8'h96;
      drive(1'b0, C);
      for (int i = 0; i < 4; i++) drive(b[i], C);
      drive(b[4], 2);
      rx_rst = 1'b1;
      @(negedge clk);
      rx_rst    = 1'b0;
      rx_in     = 1'b1;
      last_good = 8'h00;
      check("midrst_data", 32'(rx_data_out), 32'h00);
      check("midrst_valid", 32'(rx_valid), 32'h0);
      check("midrst_busy", 32'(rx_busy), 32'h0);
      check("midrst_err", 32'(rx_frame_err), 32'h0);
      drive(1'b1, 2 * C);
      send_frame(8'h69, 1'b1);
      drive(1'b1, 2 * C);

      // Random frames, gaps and occasional framing errors.
      for (int k = 0; k < 24; k++) begin
         b = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) begin
            send_frame(b, 1'b0);
            drive(1'b0, $urandom_range(0, 3 * C));
            drive(1'b1, $urandom_range(2, 2 * C));
         end else begin
            send_frame(b, 1'b1);
            drive(1'b1, $urandom_range(0, 2 * C));
         end
      end
      drive(1'b1, 2 * C);

      for (int i = 0; i < 20 * C && exp_q.size() != 0; i++) @(negedge clk);
      check("all_events_seen", 32'(exp_q.size()), 32'h0);
      check("final_data", 32'(rx_data_out), 32'(last_good));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
